// File: rtl/power_bar_pkg.sv
// Shared types and constants for the charge/power bar overlay.
// Holds the FSM state type, mode selectors, default colours and the pixel bundle.
package power_bar_pkg;

  localparam int unsigned VGA_CNT_W = 11;
  localparam int unsigned RGB_W     = 12;

  localparam int unsigned MODE_SATURATE = 0;
  localparam int unsigned MODE_PINGPONG = 1;

  localparam logic [RGB_W-1:0] DEF_COLOR_FILL   = 12'hF00;
  localparam logic [RGB_W-1:0] DEF_COLOR_FULL   = 12'hFF0;
  localparam logic [RGB_W-1:0] DEF_COLOR_BORDER = 12'h000;

  typedef enum logic [1:0] {
    StIdle,
    StCharge,
    StFull,
    StCooldown
  } pbar_state_t;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] hcount;
    logic [VGA_CNT_W-1:0] vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
    logic [RGB_W-1:0]     rgb;
  } vga_px_t;

  // Half-open interval test: lo <= val < hi.
  function automatic logic in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between overlay stages.
// vga_in is the consuming side, vga_out the producing side.
interface vga_if;
  import power_bar_pkg::*;

  logic [VGA_CNT_W-1:0] hcount;
  logic [VGA_CNT_W-1:0] vcount;
  logic                 hsync;
  logic                 vsync;
  logic                 hblnk;
  logic                 vblnk;
  logic [RGB_W-1:0]     rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/pbar_level_ctrl.sv
// Charge FSM: steps the level while charge is held, emits the released level as a
// one-cycle force pulse, then locks out new charges for a number of frames.
module pbar_level_ctrl
  import power_bar_pkg::*;
#(
  parameter int unsigned MAX_LEVEL       = 128,
  parameter int unsigned STEP_INTERVAL   = 1_234_177,
  parameter int unsigned MODE            = MODE_SATURATE,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             charge_i,
  input  logic                             cancel_i,
  input  logic                             vsync_i,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   level_o,
  output logic                             bar_on_o,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   throw_force_o,
  output logic                             force_valid_o,
  output logic                             busy_o
);

  localparam int unsigned FORCE_W = $clog2(MAX_LEVEL + 1);
  localparam int unsigned StepW   = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int unsigned FrameW  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [StepW-1:0]   StepLast  = StepW'(STEP_INTERVAL - 1);
  localparam logic [FrameW-1:0]  FrameLast = FrameW'(COOLDOWN_FRAMES - 1);
  localparam logic [FORCE_W-1:0] LvlMax    = FORCE_W'(MAX_LEVEL);
  localparam logic [FORCE_W-1:0] LvlOne    = FORCE_W'(1);

  pbar_state_t        state_q, state_d;
  logic [StepW-1:0]   step_cnt_q, step_cnt_d;
  logic [FORCE_W-1:0] level_q, level_d;
  logic [FORCE_W-1:0] force_q, force_d;
  logic [FrameW-1:0]  frame_cnt_q, frame_cnt_d;
  logic               dir_up_q, dir_up_d;
  logic               valid_q, valid_d;
  logic               charge_prev_q, vsync_prev_q;

  logic charge_rise, charge_fall, vsync_rise, step_now;

  // Edge detectors run in every state so a charge held across cooldown exit is not a new press.
  assign charge_rise = charge_i & ~charge_prev_q;
  assign charge_fall = ~charge_i & charge_prev_q;
  assign vsync_rise  = vsync_i & ~vsync_prev_q;
  assign step_now    = (step_cnt_q == StepLast);

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    level_d     = level_q;
    force_d     = force_q;
    frame_cnt_d = frame_cnt_q;
    dir_up_d    = dir_up_q;
    valid_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (charge_rise) begin
          state_d    = StCharge;
          level_d    = '0;
          step_cnt_d = '0;
          dir_up_d   = 1'b1;
        end
      end

      StCharge, StFull: begin
        if (cancel_i) begin
          state_d    = StIdle;
          level_d    = '0;
          step_cnt_d = '0;
        end else if (charge_fall) begin
          // Capture the pre-step level; a coincident step is dropped.
          force_d     = level_q;
          valid_d     = 1'b1;
          state_d     = StCooldown;
          frame_cnt_d = '0;
        end else if (state_q == StCharge) begin
          if (step_now) begin
            step_cnt_d = '0;
            if (MODE == MODE_PINGPONG) begin
              if (dir_up_q) begin
                level_d = level_q + LvlOne;
                if (level_d == LvlMax) dir_up_d = 1'b0;
              end else begin
                level_d = level_q - LvlOne;
                if (level_d == '0) dir_up_d = 1'b1;
              end
            end else begin
              level_d = level_q + LvlOne;
              if (level_d == LvlMax) state_d = StFull;
            end
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end

      StCooldown: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_d = StIdle;
          level_d = '0;
        end else if (vsync_rise) begin
          if (frame_cnt_q == FrameLast) begin
            state_d     = StIdle;
            level_d     = '0;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      step_cnt_q    <= '0;
      level_q       <= '0;
      force_q       <= '0;
      frame_cnt_q   <= '0;
      dir_up_q      <= 1'b1;
      valid_q       <= 1'b0;
      charge_prev_q <= 1'b0;
      vsync_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      level_q       <= level_d;
      force_q       <= force_d;
      frame_cnt_q   <= frame_cnt_d;
      dir_up_q      <= dir_up_d;
      valid_q       <= valid_d;
      charge_prev_q <= charge_i;
      vsync_prev_q  <= vsync_i;
    end
  end

  assign level_o       = level_q;
  assign bar_on_o      = (state_q == StCharge) || (state_q == StFull);
  assign throw_force_o = force_q;
  assign force_valid_o = valid_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: rtl/draw_power_bar.sv
// Power-bar overlay: a framed bar whose fill width tracks the charge level,
// composited over the incoming VGA stream with one registered stage.
module draw_power_bar
  import power_bar_pkg::*;
#(
  parameter int unsigned      X_START         = 876,
  parameter int unsigned      Y_START         = 400,
  parameter int unsigned      BAR_H           = 21,
  parameter int unsigned      MAX_LEVEL       = 128,
  parameter int unsigned      BORDER          = 3,
  parameter int unsigned      STEP_INTERVAL   = 1_234_177,
  parameter int unsigned      MODE            = MODE_SATURATE,
  parameter int unsigned      COOLDOWN_FRAMES = 30,
  parameter logic [RGB_W-1:0] COLOR_FILL      = DEF_COLOR_FILL,
  parameter logic [RGB_W-1:0] COLOR_FULL      = DEF_COLOR_FULL,
  parameter logic [RGB_W-1:0] COLOR_BORDER    = DEF_COLOR_BORDER
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           charge,
  input  logic                           cancel,
  output logic [$clog2(MAX_LEVEL+1)-1:0] throw_force,
  output logic                           force_valid,
  output logic                           busy,
  vga_if.vga_in                          vga_in,
  vga_if.vga_out                         vga_out
);

  localparam int unsigned FORCE_W = $clog2(MAX_LEVEL + 1);
  localparam logic [FORCE_W-1:0] LvlMax = FORCE_W'(MAX_LEVEL);

  localparam int BoxX0   = int'(X_START);
  localparam int BoxX1   = int'(X_START + MAX_LEVEL);
  localparam int BoxY0   = int'(Y_START);
  localparam int BoxY1   = int'(Y_START + BAR_H);
  localparam int FrameX0 = BoxX0 - int'(BORDER);
  localparam int FrameX1 = BoxX1 + int'(BORDER);
  localparam int FrameY0 = BoxY0 - int'(BORDER);
  localparam int FrameY1 = BoxY1 + int'(BORDER);

  logic [FORCE_W-1:0] level;
  logic               bar_on;
  int                 h_pos, v_pos;
  logic               in_box, in_ring, in_fill;
  vga_px_t            px_d, px_q;

  pbar_level_ctrl #(
    .MAX_LEVEL      (MAX_LEVEL),
    .STEP_INTERVAL  (STEP_INTERVAL),
    .MODE           (MODE),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_level_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .charge_i     (charge),
    .cancel_i     (cancel),
    .vsync_i      (vga_in.vsync),
    .level_o      (level),
    .bar_on_o     (bar_on),
    .throw_force_o(throw_force),
    .force_valid_o(force_valid),
    .busy_o       (busy)
  );

  assign h_pos   = int'(vga_in.hcount);
  assign v_pos   = int'(vga_in.vcount);
  assign in_box  = in_range(h_pos, BoxX0, BoxX1) && in_range(v_pos, BoxY0, BoxY1);
  assign in_ring = in_range(h_pos, FrameX0, FrameX1) && in_range(v_pos, FrameY0, FrameY1)
                   && !in_box;
  assign in_fill = in_range(h_pos, BoxX0, BoxX0 + int'(level)) && in_range(v_pos, BoxY0, BoxY1);

  // Level used here is the one live when the pixel arrives, not the registered-out one.
  always_comb begin
    px_d.hcount = vga_in.hcount;
    px_d.vcount = vga_in.vcount;
    px_d.hsync  = vga_in.hsync;
    px_d.vsync  = vga_in.vsync;
    px_d.hblnk  = vga_in.hblnk;
    px_d.vblnk  = vga_in.vblnk;
    px_d.rgb    = vga_in.rgb;
    if (bar_on && in_fill) begin
      px_d.rgb = (level == LvlMax) ? COLOR_FULL : COLOR_FILL;
    end else if (bar_on && in_ring) begin
      px_d.rgb = COLOR_BORDER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= '0;
    end else begin
      px_q <= px_d;
    end
  end

  assign vga_out.hcount = px_q.hcount;
  assign vga_out.vcount = px_q.vcount;
  assign vga_out.hsync  = px_q.hsync;
  assign vga_out.vsync  = px_q.vsync;
  assign vga_out.hblnk  = px_q.hblnk;
  assign vga_out.vblnk  = px_q.vblnk;
  assign vga_out.rgb    = px_q.rgb;

endmodule

// File: tb/tb_draw_power_bar.sv
// Bench for draw_power_bar: saturate and ping-pong instances share one stimulus stream and
// are checked every cycle against a closed-form model of level versus time held.
module tb_draw_power_bar;
  import power_bar_pkg::*;

  localparam int XS = 20;
  localparam int YS = 10;
  localparam int BH = 4;
  localparam int ML = 8;
  localparam int BD = 2;
  localparam int SI = 4;
  localparam int CF = 2;
  localparam logic [11:0] CFILL = 12'hF00;
  localparam logic [11:0] CFULL = 12'hFF0;
  localparam logic [11:0] CBORD = 12'h000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic charge = 1'b0;
  logic cancel = 1'b0;
  logic [3:0] tf0, tf1;
  logic fv0, fv1, busy0, busy1;
  bit rand_px = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_if vin ();
  vga_if vout0 ();
  vga_if vout1 ();

  draw_power_bar #(
    .X_START(XS), .Y_START(YS), .BAR_H(BH), .MAX_LEVEL(ML), .BORDER(BD),
    .STEP_INTERVAL(SI), .MODE(0), .COOLDOWN_FRAMES(CF)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .charge(charge), .cancel(cancel), .throw_force(tf0),
    .force_valid(fv0), .busy(busy0), .vga_in(vin), .vga_out(vout0)
  );

  draw_power_bar #(
    .X_START(XS), .Y_START(YS), .BAR_H(BH), .MAX_LEVEL(ML), .BORDER(BD),
    .STEP_INTERVAL(SI), .MODE(1), .COOLDOWN_FRAMES(CF)
  ) u_pp (
    .clk(clk), .rst_n(rst_n), .charge(charge), .cancel(cancel), .throw_force(tf1),
    .force_valid(fv1), .busy(busy1), .vga_in(vin), .vga_out(vout1)
  );

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 charging (bar shown), 2 cooldown; k = cycles since the press.
  int m_phase[2] = '{0, 0};
  int m_k[2] = '{0, 0};
  int m_force[2] = '{0, 0};
  int m_frames[2] = '{0, 0};
  bit m_fv[2] = '{0, 0};
  bit m_prev_ch = 1'b0;
  bit m_prev_vs = 1'b0;
  logic [11:0] e_rgb[2] = '{12'h0, 12'h0};
  logic [10:0] e_h = '0;
  logic [10:0] e_v = '0;
  logic [3:0]  e_sy = '0;

  function automatic int lvl_of(input int mode, input int k);
    int s = k / SI;
    int p = s % (2 * ML);
    if (mode == 0) return (s > ML) ? ML : s;
    return (p <= ML) ? p : 2 * ML - p;
  endfunction

  function automatic logic [11:0] pix(input bit vis, input int lvl, input int h, input int v,
                                      input logic [11:0] bg);
    bit in_box = (h >= XS) && (h < XS + ML) && (v >= YS) && (v < YS + BH);
    bit in_ring = (h >= XS - BD) && (h < XS + ML + BD) && (v >= YS - BD) && (v < YS + BH + BD)
                  && !in_box;
    if (!vis) return bg;
    if ((h >= XS) && (h < XS + lvl) && (v >= YS) && (v < YS + BH)) return (lvl == ML) ? CFULL : CFILL;
    if (in_ring) return CBORD;
    return bg;
  endfunction

  task automatic model_step();
    bit rise, fall, vs_rise;
    int lv;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_phase[d] = 0; m_k[d] = 0; m_force[d] = 0; m_frames[d] = 0; m_fv[d] = 0;
        e_rgb[d] = '0;
      end
      m_prev_ch = 0; m_prev_vs = 0; e_h = '0; e_v = '0; e_sy = '0;
      return;
    end
    rise = charge && !m_prev_ch;
    fall = !charge && m_prev_ch;
    vs_rise = vin.vsync && !m_prev_vs;
    e_h = vin.hcount;
    e_v = vin.vcount;
    e_sy = {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk};
    for (int d = 0; d < 2; d++) begin
      lv = (m_phase[d] == 1) ? lvl_of(d, m_k[d]) : 0;
      e_rgb[d] = pix(m_phase[d] == 1, lv, int'(vin.hcount), int'(vin.vcount), vin.rgb);
      m_fv[d] = 0;
      case (m_phase[d])
        0: if (rise) begin m_phase[d] = 1; m_k[d] = 0; end
        1: begin
          if (cancel) m_phase[d] = 0;
          else if (fall) begin
            m_force[d] = lv; m_fv[d] = 1; m_phase[d] = 2; m_frames[d] = 0;
          end else m_k[d]++;
        end
        default: if (vs_rise) begin
          m_frames[d]++;
          if (m_frames[d] == CF) m_phase[d] = 0;
        end
      endcase
    end
    m_prev_ch = charge;
    m_prev_vs = vin.vsync;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic b, input logic fv, input logic [3:0] tf,
                           input logic [11:0] rgb, input logic [10:0] h, input logic [10:0] v,
                           input logic [3:0] sy);
    cmp($sformatf("busy%0d", d), 32'(b), 32'(m_phase[d] != 0));
    cmp($sformatf("force_valid%0d", d), 32'(fv), 32'(m_fv[d]));
    cmp($sformatf("throw_force%0d", d), 32'(tf), 32'(m_force[d]));
    cmp($sformatf("rgb%0d", d), 32'(rgb), 32'(e_rgb[d]));
    cmp($sformatf("timing%0d", d), {6'd0, h, v, sy}, {6'd0, e_h, e_v, e_sy});
  endtask

  initial forever begin
    @(negedge clk);
    check_dut(0, busy0, fv0, tf0, vout0.rgb, vout0.hcount, vout0.vcount,
              {vout0.hsync, vout0.vsync, vout0.hblnk, vout0.vblnk});
    check_dut(1, busy1, fv1, tf1, vout1.rgb, vout1.hcount, vout1.vcount,
              {vout1.hsync, vout1.vsync, vout1.hblnk, vout1.vblnk});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_px) begin
      vin.hcount = 11'($urandom_range(XS + ML + 4, XS - 4));
      vin.vcount = 11'($urandom_range(YS + BH + 3, YS - 3));
      vin.rgb    = 12'($urandom);
      vin.hsync  = 1'($urandom);
      vin.hblnk  = 1'($urandom);
      vin.vblnk  = 1'($urandom);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic vsync_pulses(input int n);
    repeat (n) begin
      vin.vsync = 1'b1; tick();
      vin.vsync = 1'b0; tick();
    end
  endtask

  task automatic set_px(input int h, input int v, input logic [11:0] c);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.rgb    = c;
  endtask

  initial begin
    vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
    vin.hsync = 0; vin.vsync = 0; vin.hblnk = 0; vin.vblnk = 0;
    #1 rst_n = 1'b0;
    hold(3);
    @(negedge clk);
    cmp("rst_busy", 32'(busy0), 32'd0);
    cmp("rst_force", 32'(tf0), 32'd0);
    cmp("rst_rgb", 32'(vout0.rgb), 32'd0);
    cmp("rst_hcount", 32'(vout0.hcount), 32'd0);
    tick(); rst_n = 1'b1;
    hold(2);

    // Held for 18 cycles: four full steps of 4 cycles before release.
    tick(); charge = 1'b1;
    hold(18); charge = 1'b0;
    tick(); @(negedge clk);
    cmp("rel18_fv", 32'(fv0), 32'd1);
    cmp("rel18_force", 32'(tf0), 32'd4);
    cmp("rel18_force_pp", 32'(tf1), 32'd4);
    tick(); @(negedge clk);
    cmp("rel18_fv_one_cycle", 32'(fv0), 32'd0);

    // Press during cooldown, still held when cooldown ends: must not start.
    tick(); charge = 1'b1;
    hold(3);
    vsync_pulses(CF);
    hold(2); @(negedge clk);
    cmp("held_no_restart", 32'(busy0), 32'd0);
    tick(); charge = 1'b0;
    tick(); charge = 1'b1;
    tick(); @(negedge clk);
    cmp("restart_after_cd", 32'(busy0), 32'd1);

    // Pixel probes sampled 8, 9, 10 cycles into the charge: level is 2 throughout.
    hold(8);
    rand_px = 0;
    set_px(XS - 1, YS + 1, 12'h5A5);
    tick(); set_px(XS, YS + 1, 12'h5A5);
    @(negedge clk);
    cmp("px_left_border", 32'(vout0.rgb), 32'(CBORD));
    cmp("px_latency_h", 32'(vout0.hcount), 32'(XS - 1));
    tick(); set_px(XS + 2, YS + 1, 12'h5A5);
    @(negedge clk);
    cmp("px_fill", 32'(vout0.rgb), 32'(CFILL));
    tick(); rand_px = 1;
    @(negedge clk);
    cmp("px_past_fill_bg", 32'(vout0.rgb), 32'h5A5);
    charge = 1'b0;
    tick();
    vsync_pulses(CF);
    tick();

    // Held 40 cycles: saturate sits at full from cycle 32, ping-pong has turned back to 7.
    tick(); charge = 1'b1;
    hold(37);
    rand_px = 0; set_px(XS, YS, 12'h123);
    tick(); rand_px = 1;
    @(negedge clk);
    cmp("full_colour", 32'(vout0.rgb), 32'(CFULL));
    cmp("pp_fill_colour", 32'(vout1.rgb), 32'(CFILL));
    hold(2); charge = 1'b0;
    tick(); @(negedge clk);
    cmp("rel40_force", 32'(tf0), 32'd8);
    cmp("rel40_force_pp", 32'(tf1), 32'd7);
    vsync_pulses(CF);
    tick();

    // 12 steps: ping-pong climbs to 8 and falls back to 4.
    tick(); charge = 1'b1;
    hold(52); charge = 1'b0;
    tick(); @(negedge clk);
    cmp("pp_back_to_4", 32'(tf1), 32'd4);
    cmp("sat_stays_8", 32'(tf0), 32'd8);
    vsync_pulses(CF);
    tick();

    // Cancel mid-charge, with charge still high afterwards.
    tick(); charge = 1'b1;
    hold(10); cancel = 1'b1;
    tick(); cancel = 1'b0;
    @(negedge clk);
    cmp("cancel_idle", 32'(busy0), 32'd0);
    cmp("cancel_no_fv", 32'(fv0), 32'd0);
    cmp("cancel_keeps_force", 32'(tf0), 32'd8);
    hold(3); charge = 1'b0;

    // Cancel and release in the same cycle: cancel wins.
    tick(); charge = 1'b1;
    hold(6); charge = 1'b0; cancel = 1'b1;
    tick(); cancel = 1'b0;
    @(negedge clk);
    cmp("cancel_vs_release_fv", 32'(fv0), 32'd0);
    cmp("cancel_vs_release_busy", 32'(busy0), 32'd0);

    // Reset mid-charge drops the charge without a force.
    tick(); charge = 1'b1;
    hold(7); rst_n = 1'b0;
    tick(); @(negedge clk);
    cmp("rst_mid_busy", 32'(busy0), 32'd0);
    cmp("rst_mid_fv", 32'(fv0), 32'd0);
    charge = 1'b0;
    tick(); rst_n = 1'b1;
    hold(2);

    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(29, 0) == 0) charge = ~charge;
      cancel = ($urandom_range(59, 0) == 0);
      if ($urandom_range(5, 0) == 0) vin.vsync = ~vin.vsync;
    end
    cancel = 1'b0;
    hold(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
